// File: rtl/exc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exc_ctrl_pkg
// Shared definitions for the exception controller:
//   - CP0 register indices written by the controller (Status, Cause, EPC)
//   - bit positions of the fields kept in the Status and Cause words
//   - the ExcCode values the controller needs to name
//   - the sequencing FSM state encoding
//   - helpers that assemble full 32-bit Status / Cause words from fields
// -----------------------------------------------------------------------------
package exc_ctrl_pkg;

   // CP0 register indices
   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   // Status field positions (only these bits are modelled, the rest read 0)
   localparam int ST_IE     = 0;
   localparam int ST_EXL    = 1;
   localparam int ST_IM_LO  = 10;
   localparam int ST_IM_HI  = 15;

   // Cause field positions
   localparam int CA_EXC_LO = 2;
   localparam int CA_EXC_HI = 6;
   localparam int CA_IP_LO  = 10;
   localparam int CA_IP_HI  = 15;
   localparam int CA_BD     = 31;

   // ExcCode values
   localparam logic [4:0] EXC_INT = 5'd0;   // external interrupt
   localparam logic [4:0] EXC_SYS = 5'd8;   // syscall
   localparam logic [4:0] EXC_OV  = 5'd12;  // arithmetic overflow

   // Sequencer states
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WR_EPC    = 3'd1,
      S_WR_CAUSE  = 3'd2,
      S_WR_STATUS = 3'd3,
      S_WR_ERET   = 3'd4,
      S_REDIR     = 3'd5
   } state_e;

   // Full Status word from the modelled fields.
   function automatic logic [31:0] status_word(input logic [5:0] im,
                                               input logic       exl,
                                               input logic       ie);
      logic [31:0] w;
      w                    = '0;
      w[ST_IE]             = ie;
      w[ST_EXL]            = exl;
      w[ST_IM_HI:ST_IM_LO] = im;
      return w;
   endfunction

   // Full Cause word from the latched fields.
   function automatic logic [31:0] cause_word(input logic       bd,
                                              input logic [5:0] ip,
                                              input logic [4:0] code);
      logic [31:0] w;
      w                      = '0;
      w[CA_BD]               = bd;
      w[CA_IP_HI:CA_IP_LO]   = ip;
      w[CA_EXC_HI:CA_EXC_LO] = code;
      return w;
   endfunction

endpackage

// File: rtl/exc_prio.sv
// -----------------------------------------------------------------------------
// exc_prio
// Combinational arbiter deciding which request (if any) the controller accepts
// while idle. Priority: synchronous exception > enabled interrupt > ERET.
// Lower-priority requests in the same cycle are simply not taken.
//
// Ports
//   exc_valid, exc_code  : synchronous exception request and its ExcCode
//   int_req              : level-sensitive hardware interrupt lines
//   im, ie, exl          : current shadow Status fields
//   eret                 : current instruction is ERET
//   take_exc             : accept the exception
//   take_int             : accept an interrupt
//   take_eret            : accept the ERET (only meaningful with EXL=1)
//   sel_code             : ExcCode to record in Cause for an accepted entry
// -----------------------------------------------------------------------------
module exc_prio
   import exc_ctrl_pkg::*;
(
   input  logic       exc_valid,
   input  logic [4:0] exc_code,
   input  logic [5:0] int_req,
   input  logic [5:0] im,
   input  logic       ie,
   input  logic       exl,
   input  logic       eret,
   output logic       take_exc,
   output logic       take_int,
   output logic       take_eret,
   output logic [4:0] sel_code
);

   logic int_pend;

   // An interrupt is only deliverable when some unmasked line is high, global
   // enable is set, and we are not already inside a handler.
   assign int_pend  = (|(int_req & im)) & ie & ~exl;

   assign take_exc  = exc_valid;
   assign take_int  = ~exc_valid & int_pend;
   // ERET outside a handler is a no-op, so it is not "taken" at all.
   assign take_eret = ~exc_valid & ~int_pend & eret & exl;

   assign sel_code  = exc_valid ? exc_code : EXC_INT;

endmodule

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl
// Exception / interrupt entry and ERET sequencer for a MIPS-style pipeline.
// On accepting an exception or interrupt it writes EPC, Cause and Status into
// the CP0 register file over three cycles and then redirects the PC to the
// exception vector. On ERET (inside a handler) it clears Status.EXL and
// redirects to the saved EPC. Shadow copies of Status and EPC are kept here so
// decisions never need a CP0 read port; software MTC0 writes are mirrored in.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   int_req[5:0]            : hardware interrupt lines (level)
//   exc_valid, exc_code     : synchronous exception and its ExcCode
//   pc, bd                  : current instruction PC and delay-slot flag
//   eret                    : current instruction is ERET
//   sw_w, sw_a, sw_wd       : software MTC0 write, mirrored into the shadows
//   cp0_w, cp0_a, cp0_wd    : write port into the CP0 register file
//   redirect, redirect_pc   : one-cycle PC redirect strobe and target
//   stall                   : freeze pipeline/PC while sequencing
// -----------------------------------------------------------------------------
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  int_req,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic [31:0] pc,
   input  logic        bd,
   input  logic        eret,
   input  logic        sw_w,
   input  logic [4:0]  sw_a,
   input  logic [31:0] sw_wd,
   output logic        cp0_w,
   output logic [4:0]  cp0_a,
   output logic [31:0] cp0_wd,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        stall
);

   // ---------------------------------------------------------------- state
   state_e      state_q,   state_d;

   // Fields latched at accept time
   logic [31:0] epc_lat_q, epc_lat_d;
   logic [4:0]  code_q,    code_d;
   logic [5:0]  ip_q,      ip_d;
   logic        bd_q,      bd_d;
   logic        eret_q,    eret_d;     // selects redirect target in S_REDIR

   // Shadow Status / EPC
   logic        ie_q,      ie_d;
   logic        exl_q,     exl_d;
   logic [5:0]  im_q,      im_d;
   logic [31:0] epc_sh_q,  epc_sh_d;

   // ---------------------------------------------------------------- arbiter
   logic       take_exc;
   logic       take_int;
   logic       take_eret;
   logic [4:0] sel_code;

   exc_prio u_prio (
      .exc_valid (exc_valid),
      .exc_code  (exc_code),
      .int_req   (int_req),
      .im        (im_q),
      .ie        (ie_q),
      .exl       (exl_q),
      .eret      (eret),
      .take_exc  (take_exc),
      .take_int  (take_int),
      .take_eret (take_eret),
      .sel_code  (sel_code)
   );

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         epc_lat_q <= '0;
         code_q    <= '0;
         ip_q      <= '0;
         bd_q      <= 1'b0;
         eret_q    <= 1'b0;
         ie_q      <= 1'b0;
         exl_q     <= 1'b0;
         im_q      <= '0;
         epc_sh_q  <= '0;
      end else begin
         state_q   <= state_d;
         epc_lat_q <= epc_lat_d;
         code_q    <= code_d;
         ip_q      <= ip_d;
         bd_q      <= bd_d;
         eret_q    <= eret_d;
         ie_q      <= ie_d;
         exl_q     <= exl_d;
         im_q      <= im_d;
         epc_sh_q  <= epc_sh_d;
      end
   end

   // ---------------------------------------------------------------- next state / outputs
   always_comb begin
      state_d     = state_q;
      epc_lat_d   = epc_lat_q;
      code_d      = code_q;
      ip_d        = ip_q;
      bd_d        = bd_q;
      eret_d      = eret_q;
      ie_d        = ie_q;
      exl_d       = exl_q;
      im_d        = im_q;
      epc_sh_d    = epc_sh_q;

      cp0_w       = 1'b0;
      cp0_a       = '0;
      cp0_wd      = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      stall       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (take_exc || take_int) begin
               stall     = 1'b1;
               // Delay-slot instructions restart at the branch (wraps mod 2^32).
               epc_lat_d = bd ? (pc - 32'd4) : pc;
               code_d    = sel_code;
               ip_d      = int_req;
               bd_d      = bd;
               eret_d    = 1'b0;
               state_d   = S_WR_EPC;
            end else if (take_eret) begin
               stall     = 1'b1;
               eret_d    = 1'b1;
               state_d   = S_WR_ERET;
            end else if (sw_w) begin
               // Mirror software writes only when the instruction is not being
               // pre-empted by an entry/return sequence this cycle.
               if (sw_a == CP0_STATUS) begin
                  ie_d  = sw_wd[ST_IE];
                  exl_d = sw_wd[ST_EXL];
                  im_d  = sw_wd[ST_IM_HI:ST_IM_LO];
               end else if (sw_a == CP0_EPC) begin
                  epc_sh_d = sw_wd;
               end
            end
         end

         S_WR_EPC: begin
            stall    = 1'b1;
            cp0_w    = 1'b1;
            cp0_a    = CP0_EPC;
            cp0_wd   = epc_lat_q;
            epc_sh_d = epc_lat_q;
            state_d  = S_WR_CAUSE;
         end

         S_WR_CAUSE: begin
            stall   = 1'b1;
            cp0_w   = 1'b1;
            cp0_a   = CP0_CAUSE;
            cp0_wd  = cause_word(bd_q, ip_q, code_q);
            state_d = S_WR_STATUS;
         end

         S_WR_STATUS: begin
            stall   = 1'b1;
            cp0_w   = 1'b1;
            cp0_a   = CP0_STATUS;
            cp0_wd  = status_word(im_q, 1'b1, ie_q);
            exl_d   = 1'b1;
            state_d = S_REDIR;
         end

         S_WR_ERET: begin
            stall   = 1'b1;
            cp0_w   = 1'b1;
            cp0_a   = CP0_STATUS;
            cp0_wd  = status_word(im_q, 1'b0, ie_q);
            exl_d   = 1'b0;
            state_d = S_REDIR;
         end

         S_REDIR: begin
            stall       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = eret_q ? epc_sh_q : EXC_VECTOR;
            state_d     = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on posedge clk.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 int_req  in  6  hardware interrupt lines, level-sensitive.
REQ-004 exc_valid  in  1  synchronous exception raised by the current instruction.
REQ-005 exc_code  in  5  MIPS ExcCode for exc_valid.
REQ-006 pc  in  32  PC of the current instruction.
REQ-007 bd  in  1  current instruction is in a branch delay slot.
REQ-008 eret  in  1  current instruction is ERET.
REQ-009 sw_w, sw_a, sw_wd  in  1/5/32  software MTC0 write, mirrored into the shadows.
REQ-010 cp0_w, cp0_a, cp0_wd  out  1/5/32  write port driving the CP0 register file.
REQ-011 redirect  out  1  one-cycle PC redirect strobe.
REQ-012 redirect_pc  out  32  redirect target, valid while redirect=1.
REQ-013 stall  out  1  freeze the pipeline/PC.
REQ-014 Parameter EXC_VECTOR, default 32'h0000_0180: exception entry address.

Function
REQ-015 Shadow Status (IE=bit0, EXL=bit1, IM=bits15:10) and shadow EPC are held internally; all other bits read 0.
REQ-016 sw_w=1 with sw_a=12 loads the Status shadow; sw_a=14 loads the EPC shadow; other addresses are ignored; this applies in IDLE only.
REQ-017 FSM states: IDLE, WR_EPC, WR_CAUSE, WR_STATUS, WR_ERET, REDIR.
REQ-018 Interrupt is taken iff (int_req & IM) != 0, IE=1 and EXL=0.
REQ-019 Priority in IDLE: exc_valid > taken interrupt > eret; a lower-priority request in the same cycle is dropped.
REQ-020 Exception/interrupt accept (IDLE, cycle N): latch EPC = bd ? pc-4 : pc, code = exc_valid ? exc_code : 0, IP = int_req, BD = bd; next state WR_EPC.
REQ-021 WR_EPC (N+1): cp0_w=1, cp0_a=14, cp0_wd=latched EPC; EPC shadow updated.
REQ-022 WR_CAUSE (N+2): cp0_w=1, cp0_a=13, cp0_wd = {BD,15'b0,IP[5:0],3'b0,code[4:0],2'b0} (BD bit31, IP bits15:10, ExcCode bits6:2).
REQ-023 WR_STATUS (N+3): cp0_w=1, cp0_a=12, cp0_wd = shadow Status with EXL=1; shadow updated.
REQ-024 REDIR (N+4): redirect=1, redirect_pc=EXC_VECTOR; return to IDLE at N+5.
REQ-025 ERET accept (IDLE, N, EXL=1): WR_ERET at N+1 (cp0_w=1, cp0_a=12, EXL cleared); REDIR at N+2 with redirect_pc = shadow EPC.
REQ-026 ERET with EXL=0 is a no-op: no writes, no redirect, no stall.
REQ-027 stall = (state != IDLE) | (IDLE & request accepted this cycle); it is combinational.
REQ-028 In non-IDLE states all inputs except reset are ignored; there is no queuing.
REQ-029 Outside the write states cp0_w=0, and cp0_a/cp0_wd=0; outside REDIR redirect=0 and redirect_pc=0.
REQ-030 PC arithmetic is 32-bit modulo 2^32 (pc=0 with bd=1 yields EPC=32'hFFFF_FFFC).

Reset
REQ-031 reset=1 at a posedge forces IDLE and clears the Status shadow, EPC shadow and latched fields to 0; all outputs are 0 in the following cycle.
REQ-032 reset mid-sequence aborts it; no further CP0 writes or redirect are issued.
REQ-033 reset has priority over every other input, including sw_w.

Structure
REQ-034 A shared package holds the CP0 register indices (STATUS=12, CAUSE=13, EPC=14), the Status/Cause bit positions, ExcCode constants and the FSM state encoding.
REQ-035 There is one sub-module, exc_prio: a combinational arbiter producing take_exc, take_int, take_eret and the selected code.

Verification
REQ-036 Status=0x0000_0401, int_req=6'b000001, pc=0x100 -> writes (14,0x100), (13,0x400), (12,0x403) at N+1 through N+3, then redirect to 0x180 at N+4, with stall high N through N+4.
REQ-037 exc_valid=1, exc_code=8, int_req active, bd=1, pc=0x204 -> EPC=0x200, Cause=0x8000_0420, and the interrupt is ignored.
REQ-038 EXL=1, eret=1, EPC shadow=0x200 -> Status write with EXL=0 at N+1, redirect to 0x200 at N+2; eret with EXL=0 -> no activity.
REQ-039 Interrupt with IE=0, or with IM masking the line, or with EXL=1 -> stall=0 and no writes.
REQ-040 reset asserted during WR_CAUSE -> cp0_w=0 next cycle, no redirect, shadows read 0.
REQ-041 exc_valid pulse during WR_STATUS -> ignored; exactly one sequence is executed.
